// File: rtl/pe_pkg.sv
// Shared types and helpers for the multi-precision systolic PE.
// sat_acc clamps a wide signed sum into a signed acc_w-bit range and reports whether it clamped.
package pe_pkg;

    typedef enum logic [1:0] {
        MODE_FXP = 2'b00,
        MODE_INT = 2'b01,
        MODE_PK2 = 2'b10,
        MODE_PK4 = 2'b11
    } pe_mode_e;

    // Widest accumulator the saturation helper supports.
    localparam int SAT_W_MAX = 64;

    typedef struct packed {
        logic [SAT_W_MAX-1:0] value;
        logic                 clamped;
    } sat_res_t;

    function automatic sat_res_t sat_acc(input logic signed [SAT_W_MAX:0] sum, input int acc_w);
        logic signed [SAT_W_MAX:0] max_v;
        logic signed [SAT_W_MAX:0] min_v;
        sat_res_t                  res;
        max_v       = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
        min_v       = -(65'sd1 <<< (acc_w - 1));
        res.value   = sum[SAT_W_MAX-1:0];
        res.clamped = 1'b0;
        if (sum > max_v) begin
            res.value   = max_v[SAT_W_MAX-1:0];
            res.clamped = 1'b1;
        end else if (sum < min_v) begin
            res.value   = min_v[SAT_W_MAX-1:0];
            res.clamped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_packed_dot.sv
// Combinational multi-precision multiplier: full product, rounded fixed-point product,
// or the sum of 2 / 4 packed signed lane products, sign-extended to ACC_W.
module pe_packed_dot
    import pe_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int FRAC_BITS = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] w_i,
    input  pe_mode_e          mode_i,
    output logic [ACC_W-1:0]  dot_o
);

    localparam int PW = 2 * DATA_W;
    localparam int H  = DATA_W / 2;
    localparam int Q  = DATA_W / 4;
    localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC_BITS - 1);

    logic signed [PW-1:0]     prod_full;
    logic signed [DATA_W-1:0] lane2 [2];
    logic signed [H-1:0]      lane4 [4];
    logic signed [ACC_W-1:0]  pk2_v;
    logic signed [ACC_W-1:0]  pk4_v;

    assign prod_full = PW'($signed(a_i)) * PW'($signed(w_i));

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_lane2
        assign lane2[gi] = DATA_W'($signed(a_i[gi*H +: H])) * DATA_W'($signed(w_i[gi*H +: H]));
    end
    for (gi = 0; gi < 4; gi++) begin : g_lane4
        assign lane4[gi] = H'($signed(a_i[gi*Q +: Q])) * H'($signed(w_i[gi*Q +: Q]));
    end

    always_comb begin
        pk2_v = '0;
        pk4_v = '0;
        for (int i = 0; i < 2; i++) pk2_v += ACC_W'(lane2[i]);
        for (int i = 0; i < 4; i++) pk4_v += ACC_W'(lane4[i]);
    end

    // Fixed point rounds half-up: add half an LSB, then floor via arithmetic shift.
    always_comb begin
        dot_o = '0;
        case (mode_i)
            MODE_FXP: dot_o = ACC_W'((prod_full + RND) >>> FRAC_BITS);
            MODE_INT: dot_o = ACC_W'(prod_full);
            MODE_PK2: dot_o = pk2_v;
            MODE_PK4: dot_o = pk4_v;
            default:  dot_o = '0;
        endcase
    end

endmodule

// File: rtl/pe_mp.sv
// Weight-stationary systolic PE: double-buffered weights, east/south forwarding,
// optional multiply pipeline stage and saturating/wrapping accumulation.
module pe_mp
    import pe_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int FRAC_BITS = 8,
    parameter int PIPE_MUL  = 1,
    parameter int SAT_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        sys_mode,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic [DATA_W-1:0] weight_in,
    input  logic              accept_w_in,
    input  logic [DATA_W-1:0] input_in,
    input  logic              valid_in,
    input  logic              switch_in,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid,
    output logic              sat_out,
    output logic [DATA_W-1:0] weight_out,
    output logic              accept_w_out,
    output logic [DATA_W-1:0] input_out,
    output logic              valid_out,
    output logic              switch_out
);

    logic [DATA_W-1:0] shadow_q, active_q, eff_w;
    logic [DATA_W-1:0] weight_out_q, input_out_q;
    logic              accept_w_out_q, valid_out_q, switch_out_q;
    logic [ACC_W-1:0]  psum_out_q;
    logic              psum_valid_q, sat_out_q;

    logic [ACC_W-1:0]  alu;
    logic [ACC_W-1:0]  alu_s, psum_s;
    logic              valid_s;
    logic signed [ACC_W:0] sum_d;
    sat_res_t          sat_res;
    logic              sat_unused;
    logic [ACC_W-1:0]  psum_d;
    logic              sat_d;

    // A beat arriving with switch_in already sees the weight being promoted.
    assign eff_w = switch_in ? shadow_q : active_q;

    pe_packed_dot #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_dot (
        .a_i    (input_in),
        .w_i    (eff_w),
        .mode_i (pe_mode_e'(sys_mode)),
        .dot_o  (alu)
    );

    // The mode is fully consumed by the multiplier, so the staged product already carries it.
    generate
        if (PIPE_MUL != 0) begin : g_pipe
            logic [ACC_W-1:0] alu_q, psum_q;
            logic             valid_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    alu_q   <= '0;
                    psum_q  <= '0;
                    valid_q <= 1'b0;
                end else if (en) begin
                    alu_q   <= alu;
                    psum_q  <= psum_in;
                    valid_q <= valid_in;
                end
            end
            assign alu_s   = alu_q;
            assign psum_s  = psum_q;
            assign valid_s = valid_q;
        end else begin : g_direct
            assign alu_s   = alu;
            assign psum_s  = psum_in;
            assign valid_s = valid_in;
        end
    endgenerate

    assign sum_d      = {alu_s[ACC_W-1], alu_s} + {psum_s[ACC_W-1], psum_s};
    assign sat_res    = sat_acc((SAT_W_MAX+1)'(sum_d), ACC_W);
    assign sat_unused = ^sat_res;

    always_comb begin
        psum_d = sum_d[ACC_W-1:0];
        sat_d  = 1'b0;
        if (SAT_EN != 0) begin
            psum_d = sat_res.value[ACC_W-1:0];
            sat_d  = sat_res.clamped;
        end
        if (!valid_s) begin
            psum_d = '0;
            sat_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q       <= '0;
            active_q       <= '0;
            weight_out_q   <= '0;
            accept_w_out_q <= 1'b0;
            input_out_q    <= '0;
            valid_out_q    <= 1'b0;
            switch_out_q   <= 1'b0;
            psum_out_q     <= '0;
            psum_valid_q   <= 1'b0;
            sat_out_q      <= 1'b0;
        end else if (en) begin
            if (accept_w_in) shadow_q <= weight_in;
            if (switch_in)   active_q <= shadow_q;
            weight_out_q   <= accept_w_in ? weight_in : '0;
            accept_w_out_q <= accept_w_in;
            if (valid_in)    input_out_q <= input_in;
            valid_out_q    <= valid_in;
            switch_out_q   <= switch_in;
            psum_out_q     <= psum_d;
            psum_valid_q   <= valid_s;
            sat_out_q      <= sat_d;
        end
    end

    assign psum_out     = psum_out_q;
    assign psum_valid   = psum_valid_q;
    assign sat_out      = sat_out_q;
    assign weight_out   = weight_out_q;
    assign accept_w_out = accept_w_out_q;
    assign input_out    = input_out_q;
    assign valid_out    = valid_out_q;
    assign switch_out   = switch_out_q;

endmodule
